// File: rtl/aes_inv_key_sched.sv
// Iterative AES-128 inverse key schedule: replays round keys 10 down to 0 from the final round key.
// Optional build macro AES_INVKS_ZEROIZE_EN: masks rk when invalid and clears the key register at completion.
module aes_inv_key_sched #(
  parameter int NR    = 10,
  parameter int KEY_W = 128
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [KEY_W-1:0]   last_key,
  input  logic               out_ready,
  output logic               rk_valid,
  output logic [KEY_W-1:0]   rk,
  output logic [3:0]         rk_round,
  output logic               busy,
  output logic               done
);

  // Forward S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  state_t             state_reg;
  logic [KEY_W-1:0]   key_reg;
  logic [3:0]         round_reg;
  logic               valid_reg;
  logic               busy_reg;
  logic               done_reg;

  logic [31:0]        a0, a1, a2, a3;
  logic [31:0]        b0_next, b1_next, b2_next, b3_next;
  logic [31:0]        rot_word;
  logic [31:0]        sub_word;
  logic [7:0]         rcon;
  logic [KEY_W-1:0]   prev_key_next;
  logic               xfer;

  function automatic logic [7:0] rcon_of(input logic [3:0] r);
    logic [7:0] v;
    v = 8'h00;
    case (r)
      4'd1:  v = 8'h01;
      4'd2:  v = 8'h02;
      4'd3:  v = 8'h04;
      4'd4:  v = 8'h08;
      4'd5:  v = 8'h10;
      4'd6:  v = 8'h20;
      4'd7:  v = 8'h40;
      4'd8:  v = 8'h80;
      4'd9:  v = 8'h1b;
      4'd10: v = 8'h36;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  assign a0 = key_reg[127:96];
  assign a1 = key_reg[95:64];
  assign a2 = key_reg[63:32];
  assign a3 = key_reg[31:0];

  // Undo the forward word chain first; b3 is then the previous key's last word.
  assign b3_next  = a3 ^ a2;
  assign b2_next  = a2 ^ a1;
  assign b1_next  = a1 ^ a0;
  assign rot_word = {b3_next[23:0], b3_next[31:24]};

  for (genvar gi = 0; gi < 4; gi++) begin : g_sbox
    assign sub_word[gi*8 +: 8] = SBOX[{~rot_word[gi*8 +: 8], 3'b000} +: 8];
  end

  assign rcon          = rcon_of(round_reg);
  assign b0_next       = a0 ^ sub_word ^ {rcon, 24'h0};
  assign prev_key_next = {b0_next, b1_next, b2_next, b3_next};
  assign xfer          = valid_reg & out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      key_reg   <= '0;
      round_reg <= 4'd0;
      valid_reg <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          done_reg <= 1'b0;
          if (start) begin
            key_reg   <= last_key;
            round_reg <= 4'(NR);
            valid_reg <= 1'b1;
            busy_reg  <= 1'b1;
            state_reg <= EMIT;
          end
        end
        EMIT: begin
          if (xfer) begin
            if (round_reg == 4'd0) begin
              valid_reg <= 1'b0;
              busy_reg  <= 1'b0;
              done_reg  <= 1'b1;
              state_reg <= IDLE;
`ifdef AES_INVKS_ZEROIZE_EN
              key_reg   <= '0;
`endif
            end else begin
              key_reg   <= prev_key_next;
              round_reg <= round_reg - 4'd1;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign rk_valid = valid_reg;
  assign rk_round = round_reg;
  assign busy     = busy_reg;
  assign done     = done_reg;

`ifdef AES_INVKS_ZEROIZE_EN
  assign rk = valid_reg ? key_reg : '0;
`else
  assign rk = key_reg;
`endif

endmodule

// File: tb/tb_aes_inv_key_sched.sv
// Directed bench for aes_inv_key_sched using the FIPS-197 A.1 key schedule.
module tb_aes_inv_key_sched;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [127:0] last_key;
  logic         out_ready;
  logic         rk_valid;
  logic [127:0] rk;
  logic [3:0]   rk_round;
  logic         busy;
  logic         done;

  int checks   = 0;
  int failures = 0;

  logic [127:0] exp_keys [0:10];

  localparam logic [127:0] ZERO_LAST = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
  localparam logic [127:0] ALT_KEY   = 128'h00112233445566778899aabbccddeeff;
`ifdef AES_INVKS_ZEROIZE_EN
  localparam logic [127:0] POST_DONE_RK = 128'h0;
`else
  localparam logic [127:0] POST_DONE_RK = 128'h2b7e151628aed2a6abf7158809cf4f3c;
`endif

  always #5 clk = ~clk;

  aes_inv_key_sched dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .last_key (last_key),
    .out_ready(out_ready),
    .rk_valid (rk_valid),
    .rk       (rk),
    .rk_round (rk_round),
    .busy     (busy),
    .done     (done)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk128(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic chk_idle_zero(input string tag);
    chk_int({tag, "_valid"}, int'(rk_valid), 0);
    chk128({tag, "_rk"}, rk, 128'h0);
    chk_int({tag, "_round"}, int'(rk_round), 0);
    chk_int({tag, "_busy"}, int'(busy), 0);
    chk_int({tag, "_done"}, int'(done), 0);
  endtask

  // Walks one sequence showing r10 .. r0 with optional stall, stray start, or reset.
  task automatic run_seq(input bit do_start, input int stall_at, input int poke_at, input int reset_at);
    if (do_start) begin
      last_key = exp_keys[10];
      start    = 1'b1;
      step();
      start    = 1'b0;
      last_key = ALT_KEY;
    end
    for (int r = 10; r >= 0; r--) begin
      chk_int("seq_valid", int'(rk_valid), 1);
      chk_int("seq_busy", int'(busy), 1);
      chk_int("seq_round", int'(rk_round), r);
      chk128("seq_rk", rk, exp_keys[r]);
      if (r == reset_at) begin
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk_idle_zero("mid_reset");
        step();
        chk_idle_zero("post_reset");
        return;
      end
      if (r == stall_at) begin
        out_ready = 1'b0;
        repeat (3) begin
          step();
          chk_int("stall_valid", int'(rk_valid), 1);
          chk_int("stall_round", int'(rk_round), r);
          chk128("stall_rk", rk, exp_keys[r]);
        end
        out_ready = 1'b1;
      end
      if (r == poke_at) begin
        start    = 1'b1;
        last_key = ALT_KEY;
      end
      step();
      start = 1'b0;
      if (r > 0) chk_int("seq_no_done", int'(done), 0);
    end
    chk_int("end_done", int'(done), 1);
    chk_int("end_valid", int'(rk_valid), 0);
    chk_int("end_busy", int'(busy), 0);
    chk128("end_rk", rk, POST_DONE_RK);
  endtask

  initial begin
    int n_xfer;
    int exp_r;
    int cyc;

    exp_keys[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    exp_keys[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    exp_keys[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    exp_keys[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    exp_keys[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    exp_keys[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    exp_keys[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    exp_keys[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    exp_keys[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    exp_keys[9]  = 128'hac7766f319fadc2128d12941575c006e;
    exp_keys[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    reset     = 1'b1;
    start     = 1'b0;
    out_ready = 1'b1;
    last_key  = '0;
    step();
    step();
    reset = 1'b0;
    chk_idle_zero("reset_state");

    // A.1 sequence, ready held high.
    run_seq(1'b1, -1, -1, -1);
    $display("txn: A.1 sequence complete checks=%0d", checks);

    // Start in the done cycle, then backpressure on r7.
    last_key = exp_keys[10];
    start    = 1'b1;
    step();
    start    = 1'b0;
    run_seq(1'b0, 7, -1, -1);
    $display("txn: start-on-done + stall at r7 complete checks=%0d", checks);
    step();
    chk_int("done_pulse_len", int'(done), 0);
    chk128("rk_after_done", rk, POST_DONE_RK);

    // Zero-key sequence: count transfers and rounds.
    last_key = ZERO_LAST;
    start    = 1'b1;
    step();
    start    = 1'b0;
    n_xfer   = 0;
    exp_r    = 10;
    cyc      = 0;
    while (!done && cyc < 40) begin
      if (rk_valid && out_ready) begin
        chk_int("zero_round", int'(rk_round), exp_r);
        if (exp_r == 0) chk128("zero_r0", rk, 128'h0);
        n_xfer++;
        exp_r--;
      end
      step();
      cyc++;
    end
    chk_int("zero_done", int'(done), 1);
    chk_int("zero_xfers", n_xfer, 11);
    $display("txn: zero-key sequence transfers=%0d", n_xfer);
    step();

    // Stray start at r5 is ignored.
    run_seq(1'b1, -1, 5, -1);
    $display("txn: start-while-busy sequence complete checks=%0d", checks);
    step();

    // Reset at r4, then a clean replay.
    run_seq(1'b1, -1, -1, 4);
    $display("txn: reset at r4 complete checks=%0d", checks);
    run_seq(1'b1, -1, -1, -1);
    $display("txn: replay after reset complete checks=%0d", checks);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
